// File: rtl/dec_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
// Holds the FSM state type, mode encodings and the one-hot helper.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAXN    = 8;
    localparam int MAXOUTS = 2 ** MAXN;

    // Callers slice the low 2**N bits for their own width.
    function automatic logic [MAXOUTS-1:0] onehot(
        input logic [MAXN-1:0] index
    );
        onehot        = '0;
        onehot[index] = 1'b1;
    endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Dwell counter for the scanning decoder.
// Counts up on inc, clears on clr, flags terminal count at DWELL-1.
module dec_dwell_cnt #(
    parameter int DWELL = 4,
    parameter int CW    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N decoder with DIRECT and free-running SCAN modes.
// Define DEC_SCAN_BLANK_EN to insert a blank cycle on each scan step.
module dec_scan_n
    import dec_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            load,
    input  logic [N-1:0]    a,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);

    localparam int OUTS = 2 ** N;

    dec_state_t state_q;
    dec_state_t state_n;

    logic [N-1:0]       idx_n;
    logic [OUTS-1:0]    y_n;
    logic               valid_n;
    logic               wrap_n;
    logic               blank_n;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               tc;
    logic [MAXOUTS-1:0] oh_full;

`ifdef DEC_SCAN_BLANK_EN
    logic blank_q;
`endif

    dec_dwell_cnt #(
        .DWELL (DWELL),
        .CW    (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (tc)
    );

    always_comb begin
        state_n = IDLE;
        unique case (1'b1)
            !en:                        state_n = IDLE;
            en && mode == MODE_DIRECT:  state_n = DIRECT;
            default:                    state_n = SCAN;
        endcase
    end

    always_comb begin
        idx_n   = idx;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        blank_n = 1'b0;
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        unique case (state_n)
            DIRECT: begin
                if (load) idx_n = a;
                valid_n = 1'b1;
            end
            SCAN: begin
                if (load) begin
                    idx_n = a;
                end else if (state_q == SCAN) begin
`ifdef DEC_SCAN_BLANK_EN
                    // Counter stays cleared through the blank cycle.
                    if (!blank_q) begin
                        if (tc) begin
                            idx_n   = idx + 1'b1;
                            wrap_n  = &idx;
                            blank_n = 1'b1;
                        end else begin
                            cnt_clr = 1'b0;
                            cnt_inc = 1'b1;
                        end
                    end
`else
                    if (tc) begin
                        idx_n  = idx + 1'b1;
                        wrap_n = &idx;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
`endif
                end
                valid_n = !blank_n;
            end
            default: ;
        endcase
        oh_full = onehot(MAXN'(idx_n));
        y_n     = valid_n ? oh_full[OUTS-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx     <= '0;
            y       <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_n;
            idx     <= idx_n;
            y       <= y_n;
            valid   <= valid_n;
            wrap    <= wrap_n;
        end
    end

`ifdef DEC_SCAN_BLANK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_n;
        end
    end
`endif

endmodule
